// File: rtl/zbuf_depth_test_if.sv
// Fragment upstream/downstream handshakes and z-buffer memory port
// of the depth-test unit.
interface zbuf_depth_test_if;
    logic        nd;
    logic        us_rfd;
    logic [31:0] zbuff_addr;
    logic [15:0] frag_z;
    logic        ds_rfd;
    logic        rdy;
    logic        pass;
    logic [31:0] out_addr;
    logic [15:0] out_z;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;

    modport master (
        output nd, zbuff_addr, frag_z, ds_rfd, mem_rdata, mem_ack,
        input  us_rfd, rdy, pass, out_addr, out_z,
        input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        input  pass_cnt, fail_cnt
    );

    modport slave (
        input  nd, zbuff_addr, frag_z, ds_rfd, mem_rdata, mem_ack,
        output us_rfd, rdy, pass, out_addr, out_z,
        output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        output pass_cnt, fail_cnt
    );
endinterface

// File: rtl/zbuf_depth_test.sv
// Z-buffer depth test: read stored depth, compare, optionally write
// back, hand the result downstream and keep saturating pass/fail counts.
module zbuf_depth_test #(
    parameter int WRITE_EN = 1,
    parameter int LESS_EQ  = 0
) (
    input  logic              clk,
    input  logic              rst,
    zbuf_depth_test_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, READ, TEST, WRITE, OUT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [15:0] z_q;
    logic [15:0] stored_q;
    logic [15:0] pass_cnt_q;
    logic [15:0] fail_cnt_q;
    logic        pass_q;
    logic        z_nan;
    logic        s_nan;
    logic        cmp;
    logic        test_pass;
    logic        xfer;

    // fp16 NaN: all-ones exponent with a non-zero mantissa
    assign z_nan = (&z_q[14:10]) && (|z_q[9:0]);
    assign s_nan = (&stored_q[14:10]) && (|stored_q[9:0]);
    assign cmp   = (LESS_EQ != 0) ? (z_q <= stored_q) : (z_q < stored_q);
    assign test_pass = !z_nan && (s_nan || cmp);
    assign xfer  = (state == OUT) && bus.ds_rfd;

    always_comb begin
        state_nxt      = state;
        bus.us_rfd     = 1'b0;
        bus.rdy        = 1'b0;
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        unique case (state)
            IDLE: begin
                bus.us_rfd = 1'b1;
                if (bus.nd) state_nxt = READ;
            end
            READ: begin
                bus.mem_rd_req = 1'b1;
                bus.mem_addr   = addr_q;
                if (bus.mem_ack) state_nxt = TEST;
            end
            TEST: begin
                if (test_pass && (WRITE_EN != 0)) state_nxt = WRITE;
                else state_nxt = OUT;
            end
            WRITE: begin
                bus.mem_wr_req = 1'b1;
                bus.mem_addr   = addr_q;
                bus.mem_wdata  = z_q;
                if (bus.mem_ack) state_nxt = OUT;
            end
            OUT: begin
                bus.rdy = 1'b1;
                if (bus.ds_rfd) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            z_q        <= '0;
            stored_q   <= '0;
            pass_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            // negative depths clamp to zero as they are captured
            if (state == IDLE && bus.nd) begin
                addr_q <= bus.zbuff_addr;
                z_q    <= bus.frag_z[15] ? 16'h0000 : bus.frag_z;
            end
            if (state == READ && bus.mem_ack) stored_q <= bus.mem_rdata;
            if (state == TEST) pass_q <= test_pass;
            if (xfer) begin
                if (pass_q) begin
                    if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
                end else begin
                    if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.pass     = pass_q;
    assign bus.out_addr = addr_q;
    assign bus.out_z    = z_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.fail_cnt = fail_cnt_q;
endmodule

// File: tb/tb_zbuf_depth_test.sv
// Bench for zbuf_depth_test: vector table through a strict-compare unit,
// plus reset, saturation and less-or-equal sequences.
module tb_zbuf_depth_test;
    typedef struct {
        logic [31:0] addr;
        logic [15:0] z;
        logic [15:0] stored;
        int          dly;
        int          hold;
        bit          busy_nd;
        bit          exp_pass;
        logic [15:0] exp_z;
    } vec_t;

    typedef struct {
        bit          pass;
        logic [31:0] addr;
        logic [15:0] z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    zbuf_depth_test_if bus();
    zbuf_depth_test_if bus2();

    zbuf_depth_test #(.WRITE_EN(1), .LESS_EQ(0)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    zbuf_depth_test #(.WRITE_EN(1), .LESS_EQ(1)) dut_le (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        ack_r = 1'b0;
    logic        late_ack = 1'b0;
    logic [15:0] stored = '0;
    int          wr_cnt = 0;
    int          rd_cycles = 0;
    int          both_err = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] rd_addr = '0;
    logic [15:0] wr_data = '0;
    int          wr2_cnt = 0;
    logic [15:0] wr2_data = '0;
    logic [15:0] exp_pcnt = '0;
    logic [15:0] exp_fcnt = '0;
    vec_t        vt[10];

    assign bus.mem_ack   = ack_r | late_ack;
    assign bus.mem_rdata = stored;

    // memory model: ack after ack_delay request cycles
    always @(negedge clk) begin
        if (bus.mem_rd_req && bus.mem_wr_req) both_err++;
        if (bus.mem_rd_req || bus.mem_wr_req) begin
            ack_r = (wait_cnt >= ack_delay);
            wait_cnt++;
        end else begin
            ack_r = 1'b0;
            wait_cnt = 0;
        end
        bus2.mem_ack = bus2.mem_rd_req | bus2.mem_wr_req;
    end

    always @(posedge clk) begin
        if (bus.mem_rd_req) rd_cycles++;
        if (bus.mem_rd_req && bus.mem_ack) rd_addr = bus.mem_addr;
        if (bus.mem_wr_req && bus.mem_ack) begin
            wr_cnt++;
            wr_addr = bus.mem_addr;
            wr_data = bus.mem_wdata;
        end
        if (bus2.mem_wr_req && bus2.mem_ack) begin
            wr2_cnt++;
            wr2_data = bus2.mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic run_frag(input vec_t v);
        exp_t        e;
        int          lat;
        int          exp_lat;
        int          wr0;
        int          rc0;
        exp_lat = 3 + v.dly + (v.exp_pass ? 1 + v.dly : 0);
        chk("us_rfd_idle", bus.us_rfd, 1);
        bus.zbuff_addr = v.addr;
        bus.frag_z     = v.z;
        stored         = v.stored;
        ack_delay      = v.dly;
        bus.ds_rfd     = (v.hold == 0);
        bus.nd         = 1'b1;
        sb.push_back('{v.exp_pass, v.addr, v.exp_z});
        wr0 = wr_cnt;
        rc0 = rd_cycles;
        @(posedge clk);
        @(negedge clk);
        bus.nd = v.busy_nd;
        if (v.busy_nd) begin
            bus.zbuff_addr = ~v.addr;
            bus.frag_z     = 16'h1234;
        end
        lat = 1;
        while (!bus.rdy && lat < 40) begin
            if (v.busy_nd) chk("us_rfd_busy", bus.us_rfd, 0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        e = sb.pop_front();
        chk("pass", bus.pass, e.pass);
        chk("out_addr", bus.out_addr, e.addr);
        chk("out_z", bus.out_z, e.z);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rdy_hold", bus.rdy, 1);
            chk("out_hold", {bus.pass, bus.out_z, bus.out_addr},
                {e.pass, e.z, e.addr});
        end
        bus.nd     = 1'b0;
        bus.ds_rfd = 1'b1;
        if (e.pass) exp_pcnt = sat_inc(exp_pcnt);
        else exp_fcnt = sat_inc(exp_fcnt);
        @(posedge clk);
        @(negedge clk);
        chk("rdy_after", bus.rdy, 0);
        chk("us_rfd_back", bus.us_rfd, 1);
        chk("pass_cnt", bus.pass_cnt, exp_pcnt);
        chk("fail_cnt", bus.fail_cnt, exp_fcnt);
        chk("rd_cycles", rd_cycles - rc0, 1 + v.dly);
        chk("rd_addr", rd_addr, v.addr);
        chk("writes", wr_cnt - wr0, e.pass ? 1 : 0);
        if (e.pass) begin
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.z);
        end
    endtask

    initial begin
        int   k;
        vec_t v;
        vt[0] = '{32'h0000_0100, 16'h3800, 16'h3C00, 0, 0, 0, 1, 16'h3800};
        vt[1] = '{32'h0000_0204, 16'h3C00, 16'h3C00, 0, 0, 0, 0, 16'h3C00};
        vt[2] = '{32'h0000_0308, 16'hB800, 16'h0000, 0, 0, 0, 0, 16'h0000};
        vt[3] = '{32'h0000_040C, 16'h7E00, 16'hFC00, 0, 0, 0, 0, 16'h7E00};
        vt[4] = '{32'h0000_0510, 16'h3400, 16'h7E00, 0, 0, 0, 1, 16'h3400};
        vt[5] = '{32'h0000_0614, 16'h4000, 16'h3C00, 5, 4, 1, 0, 16'h4000};
        vt[6] = '{32'h0000_0718, 16'h0001, 16'h0002, 2, 2, 0, 1, 16'h0001};
        vt[7] = '{32'hFFFF_FFFC, 16'hFFFF, 16'h0001, 0, 0, 0, 1, 16'h0000};
        vt[8] = '{32'h0000_0820, 16'h7C00, 16'h7C00, 0, 0, 0, 0, 16'h7C00};
        vt[9] = '{32'h0000_0924, 16'h7BFF, 16'h7C00, 0, 1, 0, 1, 16'h7BFF};

        bus.nd = 1'b0; bus.zbuff_addr = '0; bus.frag_z = '0; bus.ds_rfd = 1'b1;
        bus2.nd = 1'b0; bus2.zbuff_addr = '0; bus2.frag_z = '0;
        bus2.ds_rfd = 1'b1; bus2.mem_rdata = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_us_rfd", bus.us_rfd, 1);
        chk("rst_rdy_req", {bus.rdy, bus.mem_rd_req, bus.mem_wr_req, bus.pass}, 0);
        chk("rst_out", {bus.out_addr, bus.out_z}, 0);
        chk("rst_mem", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_cnt", {bus.pass_cnt, bus.fail_cnt}, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_frag(vt[i]);

        // reset while the write-back is outstanding
        bus.zbuff_addr = 32'h0000_0ABC; bus.frag_z = 16'h2000;
        stored = 16'h3000; ack_delay = 3; bus.ds_rfd = 1'b1; bus.nd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.nd = 1'b0;
        k = 0;
        while (!bus.mem_wr_req && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("wr_req_seen", bus.mem_wr_req, 1);
        rst = 1'b0;
        #1;
        chk("rst_wr_drop", bus.mem_wr_req, 0);
        chk("rst_us_rfd2", bus.us_rfd, 1);
        chk("rst_cnt2", {bus.pass_cnt, bus.fail_cnt}, 0);
        exp_pcnt = '0;
        exp_fcnt = '0;
        @(negedge clk);
        rst = 1'b1;
        late_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        late_ack = 1'b0;
        chk("late_ack_idle", {bus.us_rfd, bus.mem_rd_req, bus.rdy}, 3'b100);
        v = '{32'h0000_0C00, 16'h1000, 16'h2000, 0, 0, 0, 1, 16'h1000};
        run_frag(v);

        // pass counter saturation
        @(negedge clk);
        force dut.pass_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.pass_cnt_q;
        exp_pcnt = 16'hFFFF;
        v = '{32'h0000_0D00, 16'h0100, 16'h0200, 0, 0, 0, 1, 16'h0100};
        run_frag(v);
        v = '{32'h0000_0D04, 16'h0300, 16'h0200, 0, 0, 0, 0, 16'h0300};
        run_frag(v);

        // less-or-equal unit: equal depths pass and write back
        bus2.zbuff_addr = 32'h0000_0055; bus2.frag_z = 16'h3C00;
        bus2.mem_rdata = 16'h3C00; bus2.nd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.nd = 1'b0;
        k = 1;
        while (!bus2.rdy && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("le_latency", k, 4);
        chk("le_pass", bus2.pass, 1);
        @(posedge clk);
        @(negedge clk);
        chk("le_write", wr2_cnt, 1);
        chk("le_wdata", wr2_data, 16'h3C00);
        chk("le_pass_cnt", bus2.pass_cnt, 1);

        chk("rd_wr_exclusive", both_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
